// File: rtl/weight_load_ctrl_pkg.sv
// Shared types and constants for the per-kernel weight path sequencer.
package cnn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } wl_state_t;

  localparam int WL_MAX_ELEMS  = 15;
  localparam int WL_WORD_ELEMS = 2;

endpackage

// File: rtl/weight_load_ctrl_if.sv
// Load-side (packed words in) and replay-side (elements out) streams.
interface weight_load_ctrl_if #(
  parameter int DATA_WIDTH = 16
) ();

  logic [31:0]           in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_vld;
  logic                  out_ready;
  logic                  out_last;

  // Controller side: consumes packed words, produces elements.
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_vld, out_last
  );

  // Environment side: AXI word source plus PE array sink.
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_vld, out_last
  );

endinterface

// File: rtl/weight_load_ctrl_store.sv
// Kernel register file: two-element word write port, one combinational read port.
module weight_store #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_ELEMS  = 15,
  parameter int IDX_W      = 4,
  parameter int WW_W       = 3
) (
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [WW_W-1:0]         wr_word,
  input  logic [2*DATA_WIDTH-1:0] wr_data,
  input  logic [IDX_W-1:0]        rd_idx,
  output logic [DATA_WIDTH-1:0]   rd_data
);

  logic [DATA_WIDTH-1:0] mem [MAX_ELEMS];

  // Word k lands in slots 2k (low half) and 2k+1 (high half); a high half
  // that falls past the last slot is simply dropped.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_ELEMS; i++) begin
      if (wr_en && ((WW_W+1)'(i) == {wr_word, 1'b0}))
        mem[i] <= wr_data[DATA_WIDTH-1:0];
      if (wr_en && ((WW_W+1)'(i) == {wr_word, 1'b1}))
        mem[i] <= wr_data[2*DATA_WIDTH-1:DATA_WIDTH];
    end
  end

  assign rd_data = (32'(rd_idx) < MAX_ELEMS) ? mem[rd_idx] : '0;

endmodule

// File: rtl/weight_load_ctrl.sv
// Loads one kernel of packed weights, then replays it to the PE array
// one element per cycle for the requested number of passes.
module weight_load_ctrl
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_ELEMS  = WL_MAX_ELEMS,
  parameter int PASS_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [4:0]        weight_dim,
  input  logic [PASS_W-1:0] num_pass,
  weight_load_ctrl_if.slave bus,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  localparam int IDX_W = $clog2(MAX_ELEMS);
  localparam int WW_W  = $clog2((MAX_ELEMS + 1) / 2);
  localparam logic [4:0] MAX_DIM = 5'(MAX_ELEMS);

  wl_state_t             state;
  logic [IDX_W-1:0]      rd_idx;
  logic [WW_W-1:0]       wr_word;
  logic [PASS_W-1:0]     pass_cnt;
  logic [PASS_W-1:0]     pass_last;
  logic [4:0]            dim_q;
  logic                  in_ready;
  logic                  out_vld;
  logic                  out_last;
  logic [4:0]            words_need;
  logic [IDX_W-1:0]      last_idx;
  logic [WW_W-1:0]       last_word;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] rd_data;

  assign words_need = (dim_q + 5'(WL_WORD_ELEMS - 1)) / 5'(WL_WORD_ELEMS);
  assign last_word  = WW_W'(words_need - 5'd1);
  assign last_idx   = IDX_W'(dim_q - 5'd1);
  assign wr_en      = (state == LOAD) && bus.in_valid && in_ready;

  weight_store #(
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_ELEMS  (MAX_ELEMS),
    .IDX_W      (IDX_W),
    .WW_W       (WW_W)
  ) u_store (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_word (wr_word),
    .wr_data (bus.in_data),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  assign bus.in_ready = in_ready;
  assign bus.out_vld  = out_vld;
  assign bus.out_last = out_last;
  assign bus.out_data = out_vld ? rd_data : '0;

  // Sequencer: IDLE -> LOAD -> STREAM (x passes) -> DONE, all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_vld   <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
      rd_idx    <= '0;
      wr_word   <= '0;
      pass_cnt  <= '0;
      pass_last <= '0;
      dim_q     <= '0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (weight_dim != 5'd0 && weight_dim <= MAX_DIM) begin
              dim_q     <= weight_dim;
              // A pass count of zero still replays once.
              pass_last <= (num_pass == '0) ? '0 : num_pass - PASS_W'(1);
              wr_word   <= '0;
              rd_idx    <= '0;
              pass_cnt  <= '0;
              in_ready  <= 1'b1;
              busy      <= 1'b1;
              state     <= LOAD;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (bus.in_valid && in_ready) begin
            if (wr_word == last_word) begin
              in_ready <= 1'b0;
              out_vld  <= 1'b1;
              out_last <= (last_idx == '0);
              state    <= STREAM;
            end else begin
              wr_word <= wr_word + WW_W'(1);
            end
          end
        end
        STREAM: begin
          if (bus.out_ready) begin
            if (rd_idx == last_idx) begin
              rd_idx <= '0;
              if (pass_cnt == pass_last) begin
                out_vld  <= 1'b0;
                out_last <= 1'b0;
                done     <= 1'b1;
                state    <= DONE;
              end else begin
                pass_cnt <= pass_cnt + PASS_W'(1);
                out_last <= (last_idx == '0);
              end
            end else begin
              rd_idx   <= rd_idx + IDX_W'(1);
              out_last <= ((rd_idx + IDX_W'(1)) == last_idx);
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Scenario bench for weight_load_ctrl: scoreboard of expected elements,
// filled when a kernel is loaded and drained as the PE side accepts data.
module tb_weight_load_ctrl;
  import cnn_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] weight_dim;
  logic [7:0] num_pass;
  logic       busy;
  logic       done;
  logic       cfg_err;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

  logic [16:0] sb [$];
  logic [31:0] w [8];

  weight_load_ctrl_if #(.DATA_WIDTH(16)) bus ();

  weight_load_ctrl #(
    .DATA_WIDTH (16),
    .MAX_ELEMS  (15),
    .PASS_W     (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .weight_dim (weight_dim),
    .num_pass   (num_pass),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (cfg_err === 1'b1) err_cnt++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Expected element stream for a kernel built from w[], repeated passes times.
  task automatic push_kernel(input int dim, input int passes);
    logic [31:0] wd;
    logic [15:0] elem;
    for (int p = 0; p < passes; p++)
      for (int e = 0; e < dim; e++) begin
        wd   = w[e/2];
        elem = (e % 2 == 1) ? wd[31:16] : wd[15:0];
        sb.push_back({(e == dim - 1), elem});
      end
  endtask

  // Called at a negedge; leaves start low at the following negedge.
  task automatic kick(input logic [4:0] d, input logic [7:0] p);
    weight_dim = d;
    num_pass   = p;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the word's handshake.
  task automatic send_word(input logic [31:0] wd);
    bit ok = 0;
    bus.in_data  = wd;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (bus.in_ready === 1'b1) ok = 1;
      else @(negedge clk);
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL load_timeout: in_ready=%b required 1 within 20 cycles", bus.in_ready);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
  endtask

  // Drains n elements through the scoreboard; returns at the negedge where the
  // n-th element is presented with out_ready high.
  task automatic collect(input int n, input bit rand_rdy, input int budget, output int cyc);
    int          got = 0;
    bit          held = 0;
    logic [15:0] hd;
    logic        hl;
    logic        rdy;
    logic [16:0] exp_v;
    cyc = 0;
    for (int c = 0; c < budget && got < n; c++) begin
      cyc++;
      rdy = rand_rdy ? ($urandom_range(1, 0) == 1) : 1'b1;
      bus.out_ready = rdy;
      if (held) begin
        n_checks++;
        if (bus.out_vld !== 1'b1 || bus.out_data !== hd || bus.out_last !== hl) begin
          n_fail++;
          $display("FAIL stall_hold: vld=%b data=%h last=%b required 1 %h %b",
                   bus.out_vld, bus.out_data, bus.out_last, hd, hl);
        end
      end
      if (bus.out_vld === 1'b1) begin
        if (rdy) begin
          n_checks++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL extra_output: data=%h required no output", bus.out_data);
          end else begin
            exp_v = sb.pop_front();
            if ({bus.out_last, bus.out_data} !== exp_v) begin
              n_fail++;
              $display("FAIL stream_elem%0d: last/data=%b/%h required %b/%h",
                       got, bus.out_last, bus.out_data, exp_v[16], exp_v[15:0]);
            end
          end
          got++;
          held = 0;
        end else begin
          held = 1;
          hd   = bus.out_data;
          hl   = bus.out_last;
        end
      end else begin
        held = 0;
        n_checks++;
        if (bus.out_data !== 16'h0 || bus.out_last !== 1'b0) begin
          n_fail++;
          $display("FAIL idle_out: data=%h last=%b required 0000 0", bus.out_data, bus.out_last);
        end
      end
      if (got < n) @(negedge clk);
    end
    if (got < n) begin
      n_checks++; n_fail++;
      $display("FAIL stream_timeout: got %0d elements required %0d", got, n);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; weight_dim = '0; num_pass = '0;
    bus.in_data = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.in_ready, bus.out_vld, bus.out_last, busy, done, cfg_err} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: rdy/vld/last/busy/done/err=%b required 000000",
               {bus.in_ready, bus.out_vld, bus.out_last, busy, done, cfg_err});
    end
    n_checks++;
    if (bus.out_data !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_data: out_data=%h required 0000", bus.out_data);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_dim4;
    int cyc;
    sb.delete();
    w = '{32'h0002_0001, 32'h0004_0003, 0, 0, 0, 0, 0, 0};
    push_kernel(4, 1);
    kick(5'd4, 8'd1);
    n_checks++;
    if (bus.in_ready !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL d4_start_latency: in_ready=%b busy=%b required 1 1", bus.in_ready, busy);
    end
    send_word(w[0]);
    send_word(w[1]);
    n_checks++;
    if (bus.in_ready !== 1'b0 || bus.out_vld !== 1'b1) begin
      n_fail++;
      $display("FAIL d4_load_to_stream: in_ready=%b out_vld=%b required 0 1", bus.in_ready, bus.out_vld);
    end
    collect(4, 1'b0, 20, cyc);
    n_checks++;
    if (cyc != 4) begin
      n_fail++;
      $display("FAIL d4_throughput: %0d cycles required 4", cyc);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b1 || bus.out_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL d4_done: done=%b busy=%b vld=%b required 1 1 0", done, busy, bus.out_vld);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL d4_idle: done=%b busy=%b required 0 0", done, busy);
    end
  endtask

  task automatic test_dim3_odd;
    int cyc;
    sb.delete();
    w = '{32'h0002_0001, 32'hDEAD_0003, 0, 0, 0, 0, 0, 0};
    push_kernel(3, 1);
    kick(5'd3, 8'd1);
    send_word(w[0]);
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL d3_mid_load: in_ready=%b required 1", bus.in_ready);
    end
    send_word(w[1]);
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL d3_ready_drop: in_ready=%b required 0", bus.in_ready);
    end
    collect(3, 1'b0, 20, cyc);
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || bus.out_vld !== 1'b0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL d3_done: done=%b vld=%b pending=%0d required 1 0 0", done, bus.out_vld, sb.size());
    end
    @(negedge clk);
  endtask

  task automatic test_dim15_stall;
    int cyc;
    sb.delete();
    for (int k = 0; k < 8; k++) w[k] = {16'(2*k + 2), 16'(2*k + 1)};
    push_kernel(15, 2);
    kick(5'd15, 8'd2);
    for (int k = 0; k < 8; k++) send_word(w[k]);
    collect(30, 1'b1, 400, cyc);
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL d15_done: done=%b pending=%0d required 1 0", done, sb.size());
    end
    @(negedge clk);
  endtask

  task automatic test_cfg_err;
    int cyc;
    logic [4:0] bad [2];
    bad = '{5'd0, 5'd20};
    for (int i = 0; i < 2; i++) begin
      kick(bad[i], 8'd1);
      n_checks++;
      if (cfg_err !== 1'b1 || bus.in_ready !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL cfg_err_dim%0d: err=%b rdy=%b busy=%b required 1 0 0",
                 bad[i], cfg_err, bus.in_ready, busy);
      end
      @(negedge clk);
      n_checks++;
      if (cfg_err !== 1'b0 || bus.in_ready !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL cfg_err_pulse_dim%0d: err=%b rdy=%b busy=%b required 0 0 0",
                 bad[i], cfg_err, bus.in_ready, busy);
      end
    end
    sb.delete();
    w[0] = 32'h0022_0011;
    push_kernel(2, 1);
    kick(5'd2, 8'd0);
    send_word(w[0]);
    collect(2, 1'b0, 20, cyc);
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL cfg_recover: done=%b pending=%0d required 1 0", done, sb.size());
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int cyc;
    sb.delete();
    for (int k = 0; k < 8; k++) w[k] = {16'(2*k + 2), 16'(2*k + 1)};
    push_kernel(15, 1);
    kick(5'd15, 8'd1);
    for (int k = 0; k < 8; k++) send_word(w[k]);
    collect(7, 1'b0, 20, cyc);
    @(negedge clk);
    rst = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.out_vld, busy, bus.in_ready, bus.out_last} !== 4'b0 || bus.out_data !== 16'h0) begin
      n_fail++;
      $display("FAIL rst_mid: vld/busy/rdy/last=%b data=%h required 0000 0000",
               {bus.out_vld, busy, bus.in_ready, bus.out_last}, bus.out_data);
    end
    rst = 1'b0;
    sb.delete();
    w[0] = 32'h00BB_00AA;
    push_kernel(2, 1);
    kick(5'd2, 8'd1);
    send_word(w[0]);
    collect(2, 1'b0, 20, cyc);
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL rst_restart: done=%b pending=%0d required 1 0", done, sb.size());
    end
    @(negedge clk);
  endtask

  task automatic test_ignored_start;
    int cyc;
    int done0;
    int err0;
    done0 = done_cnt;
    err0  = err_cnt;
    sb.delete();
    w = '{32'h0002_0001, 32'h0004_0003, 0, 0, 0, 0, 0, 0};
    push_kernel(4, 1);
    kick(5'd4, 8'd1);
    send_word(w[0]);
    kick(5'd2, 8'd3);
    weight_dim = 5'd4;
    n_checks++;
    if (bus.in_ready !== 1'b1 || cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL load_start_ignored: rdy=%b err=%b required 1 0", bus.in_ready, cfg_err);
    end
    send_word(w[1]);
    collect(4, 1'b0, 20, cyc);
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL ign_done: done=%b required 1", done);
    end
    kick(5'd4, 8'd1);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL done_start_ignored: done=%b busy=%b rdy=%b required 0 0 0",
               done, busy, bus.in_ready);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (done_cnt - done0 != 1 || err_cnt != err0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ign_counts: done pulses=%0d cfg_err pulses=%0d busy=%b required 1 0 0",
               done_cnt - done0, err_cnt - err0, busy);
    end
  endtask

  initial begin
    test_reset();
    test_dim4();
    test_dim3_odd();
    test_dim15_stall();
    test_cfg_err();
    test_reset_mid();
    test_ignored_start();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/weight_load_ctrl.md
Name: weight_load_ctrl

Overview:
- Sequencer for the per-kernel weight path.
- Accepts packed 32-bit weight words from the AXI side (two 16-bit elements per word) under a valid/ready handshake and holds one kernel of up to MAX_ELEMS elements.
- Replays that kernel to the PE array one element per cycle, NUM-pass times, under out_vld/out_ready.
- Sits between the AXI read interface and the PE array; owned by the layer controller via start/done.

Parameters:
- DATA_WIDTH, 16, width of one weight element.
- MAX_ELEMS, 15, kernel element capacity; total storage is MAX_ELEMS*DATA_WIDTH bits.
- PASS_W, 8, width of the pass-count input.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- start  in  1  one-cycle request to load and replay a kernel
- weight_dim  in  5  kernel element count; legal range 1..MAX_ELEMS
- num_pass  in  PASS_W  number of replays; 0 is treated as 1
- in_data  in  32  packed weights; [15:0] is element 2k, [31:16] is element 2k+1
- in_valid  in  1  in_data valid
- in_ready  out  1  controller accepts in_data
- out_data  out  DATA_WIDTH  weight element to the PEs
- out_vld  out  1  out_data valid
- out_ready  in  1  PE array accepts out_data
- out_last  out  1  marks the final element of each pass; qualified by out_vld
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse when the final pass completes
- cfg_err  out  1  one-cycle pulse when start is rejected

Behaviour:
- Clocking and reset are fixed: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE; in_ready, out_vld, out_last, busy, done and cfg_err all 0; out_data 0; all counters 0. Storage contents are not reset.
- out_data is forced to 0 whenever out_vld=0.
- FSM states: IDLE, LOAD, STREAM, DONE.
- IDLE:
  - start with weight_dim in 1..MAX_ELEMS: latch weight_dim and num_pass (0 becomes 1), then go to LOAD.
  - start with weight_dim 0 or >MAX_ELEMS: pulse cfg_err next cycle and stay in IDLE.
- start outside IDLE is ignored, with no cfg_err.
- LOAD:
  - in_ready=1.
  - On each in_valid&in_ready, write the word to element slots 2*wr_word and 2*wr_word+1, then increment wr_word.
  - Words needed = (dim+1)>>1.
  - For odd dim, the upper half of the last word is discarded and never streamed.
  - The cycle after the final word's handshake: in_ready=0, state=STREAM.
- STREAM:
  - out_vld=1 and out_data=store[rd_idx]; rd_idx is registered, the read mux is combinational.
  - Each out_vld&out_ready increments rd_idx.
  - out_last=1 while rd_idx==dim-1.
  - On that final handshake: rd_idx wraps to 0 and pass_cnt increments. If pass_cnt reaches the latched pass count, go to DONE; otherwise stay in STREAM with no bubble.
  - While out_ready=0, out_data and out_last are held stable.
- DONE: done=1 for one cycle, busy=0 next cycle, then IDLE. start in the DONE cycle is ignored.
- busy=1 in LOAD, STREAM and DONE.
- Latency:
  - start to first in_ready = 1 cycle.
  - Final load handshake to first out_vld = 1 cycle.
  - Steady-state throughput = 1 element per cycle.
- Arithmetic: rd_idx is clog2(MAX_ELEMS) bits; wr_word is clog2((MAX_ELEMS+1)/2) bits; pass_cnt is PASS_W bits. No counter may wrap other than at the points defined above.
- Reset mid-operation: the next cycle is IDLE with all outputs at reset values; a new start is accepted immediately.
- Simultaneous in_valid in IDLE/STREAM/DONE: not accepted, in_ready=0.

Decomposition:
- Package cnn_pkg:
  - wl_state_t enum {IDLE, LOAD, STREAM, DONE}
  - localparams WL_MAX_ELEMS=15 and WL_WORD_ELEMS=2
- Sub-module weight_store: a MAX_ELEMS x DATA_WIDTH register file with a 32-bit dual-element write port (wr_en, wr_word, wr_data) and one combinational 16-bit read port (rd_idx, rd_data).
- The controller FSM and counters stay in weight_load_ctrl.

Test Plan:
- dim=4, pass=1, words 0x0002_0001 then 0x0004_0003, out_ready=1 → out_data 1,2,3,4 on consecutive cycles; out_last only with 4; done one cycle after; busy then drops.
- dim=3, words 0x0002_0001 then 0xDEAD_0003 → exactly 3 outputs 1,2,3; 0xDEAD never appears; in_ready deasserts after the 2nd word.
- dim=15, pass=2, words 0x0002_0001..0x0010_000F, out_ready random 50% → 30 outputs (1..15 twice, i.e. 0x0001..0x000F); no drop or duplicate; out_last twice; data stable while stalled.
- weight_dim=0, and separately weight_dim=20 → cfg_err pulse, in_ready stays 0, busy stays 0; a following legal start works.
- rst asserted during STREAM at element 7 → next cycle out_vld=0 and busy=0; a new start with dim=2, word 0x00BB_00AA → outputs 0xAA, 0xBB.
- start pulsed during LOAD and during DONE → ignored; no second done, no cfg_err.
